// File: rtl/tm1638_scan_driver.sv
// tm1638_scan_driver
//   Continuously refreshes a TM1638 LED/key controller over its 3-wire bus.
//   One refresh cycle is: mode command, address+16 data bytes, display
//   control, optional key read; each serial frame is followed by a gap.
//   Display inputs are captured once per cycle so a refresh never mixes
//   old and new values.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   seg_data    segment byte per digit, digit k at [8k+7:8k], bit0 = seg a
//   leds        LED k on when 1
//   brightness  pulse-width setting 0..7
//   display_on  display enable
//   out_clk_1   serial clock to the TM1638, idle high
//   strobe      chip select, active low
//   dio         serial data out, LSB first
//   dio_oe      1 = drive dio, 0 = pad released for reading
//   dio_in      serial data from the pad
//   keys        raw key state, 1 = pressed
//   key_valid   one-clock pulse when keys is updated
//   frame_done  one-clock pulse on the last gap clock of a refresh cycle
module tm1638_scan_driver #(
  parameter int NUM_DIGITS = 3,
  parameter int CLK_DIV    = 4,
  parameter int KEY_SCAN   = 1,
  parameter int READ_WAIT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   leds,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    out_clk_1,
  output logic                    strobe,
  output logic                    dio,
  output logic                    dio_oe,
  input  logic                    dio_in,
  output logic [2*NUM_DIGITS-1:0] keys,
  output logic                    key_valid,
  output logic                    frame_done
);

  localparam int KW = 2 * NUM_DIGITS;
  localparam int CW = 16;
  // Phase counters are loaded with (length - 1) and run down to zero.
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_CNT  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_CNT = CW'(((READ_WAIT > 1) ? READ_WAIT : 1) - 1);

  typedef enum logic [2:0] {
    PH_GAP, PH_SETUP, PH_LO, PH_HI, PH_WAIT, PH_RLO, PH_RHI
  } phase_t;

  typedef enum logic [1:0] {FR_MODE, FR_DATA, FR_CTRL, FR_KEY} frame_t;

  localparam frame_t LAST_FRAME = (KEY_SCAN != 0) ? FR_KEY : FR_CTRL;

  phase_t                  phase_r;
  frame_t                  frame_r;
  frame_t                  next_frame_s;
  logic [CW-1:0]           cnt_r;
  logic [7:0]              bit_idx_r;
  logic [5:0]              rd_idx_r;
  logic                    rd_done_r;
  logic                    started_r;
  logic [KW-1:0]           key_shadow_r;
  logic [8*NUM_DIGITS-1:0] seg_snap_r;
  logic [NUM_DIGITS-1:0]   leds_snap_r;
  logic [2:0]              bright_snap_r;
  logic                    disp_snap_r;
  logic                    out_clk_r;
  logic                    strobe_r;
  logic                    dio_r;
  logic                    dio_oe_r;
  logic [KW-1:0]           keys_r;
  logic                    key_valid_r;
  logic                    frame_done_r;
  logic [127:0]            image_s;
  logic [4:0]              byte_idx_s;
  logic [3:0]              addr_s;
  logic [7:0]              tx_byte_s;
  logic                    tx_bit_s;
  logic [7:0]              nbits_s;

  assign out_clk_1  = out_clk_r;
  assign strobe     = strobe_r;
  assign dio        = dio_r;
  assign dio_oe     = dio_oe_r;
  assign keys       = keys_r;
  assign key_valid  = key_valid_r;
  assign frame_done = frame_done_r;

  // Frame sequencing; the key read is skipped in a write-only build.
  always_comb begin
    next_frame_s = FR_MODE;
    case (frame_r)
      FR_MODE: next_frame_s = FR_DATA;
      FR_DATA: next_frame_s = FR_CTRL;
      FR_CTRL: next_frame_s = (KEY_SCAN != 0) ? FR_KEY : FR_MODE;
      FR_KEY:  next_frame_s = FR_MODE;
      default: next_frame_s = FR_MODE;
    endcase
  end

  // Display RAM image: even address = segment byte, odd address = LED byte.
  always_comb begin
    image_s = 128'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      image_s[16*k +: 8]     = seg_snap_r[8*k +: 8];
      image_s[16*k + 8 +: 8] = {7'd0, leds_snap_r[k]};
    end
  end

  // Byte and bit currently on the wire; byte 0 of the data frame is 0xC0.
  always_comb begin
    byte_idx_s = bit_idx_r[7:3];
    addr_s     = bit_idx_r[6:3] - 4'd1;
    tx_byte_s  = 8'h00;
    case (frame_r)
      FR_MODE: tx_byte_s = 8'h40;
      FR_DATA: tx_byte_s = (byte_idx_s == 5'd0) ? 8'hC0 : image_s[{addr_s, 3'b000} +: 8];
      FR_CTRL: tx_byte_s = disp_snap_r ? {5'b10001, bright_snap_r} : 8'h80;
      FR_KEY:  tx_byte_s = 8'h42;
      default: tx_byte_s = 8'h00;
    endcase
    tx_bit_s = tx_byte_s[bit_idx_r[2:0]];
    nbits_s  = (frame_r == FR_DATA) ? 8'd136 : 8'd8;
  end

  // Bus sequencer: phase timing, serial shifting, key capture, pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r       <= PH_GAP;
      frame_r       <= LAST_FRAME;
      cnt_r         <= GAP_CNT;
      bit_idx_r     <= 8'd0;
      rd_idx_r      <= 6'd0;
      rd_done_r     <= 1'b0;
      started_r     <= 1'b0;
      key_shadow_r  <= '0;
      seg_snap_r    <= '0;
      leds_snap_r   <= '0;
      bright_snap_r <= 3'd0;
      disp_snap_r   <= 1'b0;
      out_clk_r     <= 1'b1;
      strobe_r      <= 1'b1;
      dio_r         <= 1'b1;
      dio_oe_r      <= 1'b1;
      keys_r        <= '0;
      key_valid_r   <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      key_valid_r  <= 1'b0;
      // Publish keys the clock after the last read bit was sampled.
      if (rd_done_r) begin
        keys_r      <= key_shadow_r;
        key_valid_r <= 1'b1;
        rd_done_r   <= 1'b0;
      end
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - 1'b1;
      end
      case (phase_r)
        PH_GAP: begin
          if (cnt_r == CW'(1) && frame_r == LAST_FRAME && started_r) begin
            frame_done_r <= 1'b1;
          end
          if (cnt_r == '0) begin
            frame_r   <= next_frame_s;
            strobe_r  <= 1'b0;
            phase_r   <= PH_SETUP;
            cnt_r     <= HALF_CNT;
            bit_idx_r <= 8'd0;
            rd_idx_r  <= 6'd0;
            if (next_frame_s == FR_MODE) begin
              seg_snap_r    <= seg_data;
              leds_snap_r   <= leds;
              bright_snap_r <= brightness;
              disp_snap_r   <= display_on;
              started_r     <= 1'b1;
            end
          end
        end
        PH_SETUP: begin
          if (cnt_r == '0) begin
            out_clk_r <= 1'b0;
            dio_r     <= tx_bit_s;
            phase_r   <= PH_LO;
            cnt_r     <= HALF_CNT;
          end
        end
        PH_LO: begin
          if (cnt_r == '0) begin
            out_clk_r <= 1'b1;
            bit_idx_r <= bit_idx_r + 8'd1;
            phase_r   <= PH_HI;
            cnt_r     <= HALF_CNT;
          end
        end
        PH_HI: begin
          // bit_idx_r already points at the next bit here.
          if (cnt_r == '0) begin
            if (bit_idx_r != nbits_s) begin
              out_clk_r <= 1'b0;
              dio_r     <= tx_bit_s;
              phase_r   <= PH_LO;
              cnt_r     <= HALF_CNT;
            end else if (frame_r == FR_KEY) begin
              dio_oe_r <= 1'b0;
              phase_r  <= PH_WAIT;
              cnt_r    <= WAIT_CNT;
            end else begin
              strobe_r <= 1'b1;
              dio_r    <= 1'b1;
              phase_r  <= PH_GAP;
              cnt_r    <= GAP_CNT;
            end
          end
        end
        PH_WAIT: begin
          if (cnt_r == '0) begin
            out_clk_r <= 1'b0;
            phase_r   <= PH_RLO;
            cnt_r     <= HALF_CNT;
          end
        end
        PH_RLO: begin
          if (cnt_r == '0) begin
            out_clk_r <= 1'b1;
            // Read bit n: byte n/8; bit 0 -> key 2b, bit 4 -> key 2b+1.
            for (int k = 0; k < KW; k++) begin
              if (k < 8 && rd_idx_r[1:0] == 2'b00 &&
                  {rd_idx_r[4:3], rd_idx_r[2]} == 3'(k)) begin
                key_shadow_r[k] <= dio_in;
              end
            end
            if (rd_idx_r == 6'd31) begin
              rd_done_r <= 1'b1;
            end
            rd_idx_r <= rd_idx_r + 6'd1;
            phase_r  <= PH_RHI;
            cnt_r    <= HALF_CNT;
          end
        end
        PH_RHI: begin
          if (cnt_r == '0) begin
            if (rd_idx_r == 6'd32) begin
              strobe_r <= 1'b1;
              dio_oe_r <= 1'b1;
              dio_r    <= 1'b1;
              phase_r  <= PH_GAP;
              cnt_r    <= GAP_CNT;
            end else begin
              out_clk_r <= 1'b0;
              phase_r   <= PH_RLO;
              cnt_r     <= HALF_CNT;
            end
          end
        end
        default: begin
          phase_r   <= PH_GAP;
          cnt_r     <= GAP_CNT;
          strobe_r  <= 1'b1;
          out_clk_r <= 1'b1;
          dio_r     <= 1'b1;
          dio_oe_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_scan_driver.sv
// Directed bench for tm1638_scan_driver (3 digits, CLK_DIV=4, READ_WAIT=8).
// Decodes each serial frame from the pins, checks bit timing, drives the
// key-read data and compares against hand-computed bytes and key maps.
module tb_tm1638_scan_driver;

  localparam int ND = 3;
  localparam int CD = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   seg_data;
  logic [2:0]    leds;
  logic [2:0]    brightness;
  logic          display_on;
  logic          out_clk_1;
  logic          strobe;
  logic          dio;
  logic          dio_oe;
  logic          dio_in;
  logic [5:0]    keys;
  logic          key_valid;
  logic          frame_done;

  int            total = 0;
  int            bad = 0;
  int            kv_cnt = 0;

  // Results of the most recent captured frame.
  int            f_to, f_gap, f_gerr, f_ntx, f_nrd, f_oel, f_terr;
  logic          f_fd;
  logic [255:0]  f_tx;

  tm1638_scan_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .KEY_SCAN(1), .READ_WAIT(RW)
  ) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .leds(leds),
    .brightness(brightness), .display_on(display_on),
    .out_clk_1(out_clk_1), .strobe(strobe), .dio(dio), .dio_oe(dio_oe),
    .dio_in(dio_in), .keys(keys), .key_valid(key_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
  end

  task automatic ck(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits through the gap, then records one strobe window. Sampling is on
  // the falling system clock. Optionally changes seg_data mid-frame and
  // serves rd_word (bit 0 first) on dio_in while the pad is released.
  task automatic cap_frame(input logic chg, input logic [23:0] chg_seg,
                           input logic [31:0] rd_word);
    int n, lo, hi, rdf;
    logic pc, pd, poe, seen_fall, last_fd, c;
    f_to = 0; f_gap = 0; f_gerr = 0; f_ntx = 0; f_nrd = 0; f_oel = 0;
    f_terr = 0; f_tx = '0; f_fd = 1'b0; last_fd = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (strobe === 1'b0) break;
      f_gap++;
      if (out_clk_1 !== 1'b1 || dio !== 1'b1 || dio_oe !== 1'b1) f_gerr++;
      last_fd = frame_done;
      n++;
      if (n > 200) begin f_to = 1; return; end
    end
    f_fd = last_fd;
    n = 0; lo = 0; hi = 0; rdf = 0;
    pc = 1'b1; pd = dio; poe = dio_oe; seen_fall = 1'b0;
    while (strobe === 1'b0) begin
      c = out_clk_1;
      if (c === 1'b0 && pc === 1'b1) begin
        if (!seen_fall) begin
          if (n != CD) f_terr++;
        end else if (hi != ((dio_oe === 1'b0 && rdf == 0) ? CD + RW : CD)) begin
          f_terr++;
        end
        seen_fall = 1'b1;
        lo = 0;
        if (dio_oe === 1'b0) begin
          dio_in = rd_word[rdf];
          rdf++;
        end
      end
      if (c === 1'b1 && pc === 1'b0) begin
        if (lo != CD) f_terr++;
        if (dio_oe === 1'b1) begin f_tx[f_ntx] = dio; f_ntx++; end
        else f_nrd++;
        hi = 0;
      end
      if (c === 1'b0) lo++; else hi++;
      if (c === 1'b1 && pc === 1'b1 && seen_fall && dio_oe === 1'b1 &&
          poe === 1'b1 && dio !== pd) f_terr++;
      if (dio_oe === 1'b0) f_oel++;
      if (chg && f_ntx == 40) seg_data = chg_seg;
      pc = c; pd = dio; poe = dio_oe;
      @(negedge clk);
      n++;
      if (n > 3000) begin f_to = 1; return; end
    end
    if (hi != CD) f_terr++;
    if (dio_oe !== 1'b1) f_terr++;
  endtask

  // The sample at which the previous capture (or reset release) stopped
  // is the first gap clock, so 2*CD-1 further gap samples are expected.
  task automatic chk_frame(input string tag, input logic exp_fd, input int exp_ntx,
                           input logic [135:0] exp_tx, input int exp_nrd, input int exp_oel);
    ck({tag, ".timeout"}, 136'(f_to), 136'(0));
    ck({tag, ".gap_len"}, 136'(f_gap), 136'(2 * CD - 1));
    ck({tag, ".gap_lvls"}, 136'(f_gerr), 136'(0));
    ck({tag, ".frame_done"}, 136'(f_fd), 136'(exp_fd));
    ck({tag, ".nbits_tx"}, 136'(f_ntx), 136'(exp_ntx));
    ck({tag, ".bytes"}, f_tx[135:0], exp_tx);
    ck({tag, ".nbits_rd"}, 136'(f_nrd), 136'(exp_nrd));
    ck({tag, ".oe_low"}, 136'(f_oel), 136'(exp_oel));
    ck({tag, ".timing"}, 136'(f_terr), 136'(0));
  endtask

  localparam int KEY_OEL = RW + 32 * 2 * CD;
  localparam logic [135:0] DATA_OLD =
    {80'h0, 8'h01, 8'hE0, 8'h00, 8'h60, 8'h01, 8'hDA, 8'hC0};
  // New digits 5B/06/3F with leds=010.
  localparam logic [135:0] DATA_NEW =
    {80'h0, 8'h00, 8'h3F, 8'h01, 8'h06, 8'h00, 8'h5B, 8'hC0};

  initial begin
    int n;
    rst = 1'b0;
    seg_data = {8'hE0, 8'h60, 8'hDA};
    leds = 3'b101;
    brightness = 3'd5;
    display_on = 1'b1;
    dio_in = 1'b1;
    repeat (3) @(negedge clk);
    ck("rst.strobe", 136'(strobe), 136'(1));
    ck("rst.out_clk", 136'(out_clk_1), 136'(1));
    ck("rst.dio", 136'(dio), 136'(1));
    ck("rst.dio_oe", 136'(dio_oe), 136'(1));
    ck("rst.keys", 136'(keys), 136'(0));
    ck("rst.key_valid", 136'(key_valid), 136'(0));
    ck("rst.frame_done", 136'(frame_done), 136'(0));
    rst = 1'b1;

    // Cycle 1
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c1.mode", 1'b0, 8, 136'h40, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c1.data", 1'b0, 136, DATA_OLD, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c1.ctrl", 1'b0, 8, 136'h8D, 0, 0);
    // Bytes 11,00,10,00: key0,key1 from byte0; byte2 bit4 -> key5.
    cap_frame(1'b0, 24'h0, 32'h0010_0011);
    chk_frame("c1.key", 1'b0, 8, 136'h42, 32, KEY_OEL);
    ck("c1.keys", 136'(keys), 136'(6'b100011));
    ck("c1.kv_pulses", 136'(kv_cnt), 136'(1));

    // Cycle 2: display off; seg_data changes in the middle of the data frame.
    display_on = 1'b0;
    brightness = 3'd3;
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c2.mode", 1'b1, 8, 136'h40, 0, 0);
    cap_frame(1'b1, {8'h3F, 8'h06, 8'h5B}, 32'h0);
    chk_frame("c2.data", 1'b0, 136, DATA_OLD, 0, 0);
    leds = 3'b010;
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c2.ctrl", 1'b0, 8, 136'h80, 0, 0);
    // Bytes 00,11,00,01: byte1 -> key2,key3; byte3 is beyond 6 keys.
    cap_frame(1'b0, 24'h0, 32'h0100_1100);
    chk_frame("c2.key", 1'b0, 8, 136'h42, 32, KEY_OEL);
    ck("c2.keys", 136'(keys), 136'(6'b001100));
    ck("c2.kv_pulses", 136'(kv_cnt), 136'(2));

    // Cycle 3: new display data; control change mid-cycle waits a cycle.
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c3.mode", 1'b1, 8, 136'h40, 0, 0);
    display_on = 1'b1;
    brightness = 3'd7;
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c3.data", 1'b0, 136, DATA_NEW, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c3.ctrl", 1'b0, 8, 136'h80, 0, 0);
    // Byte0 = 10 -> key1 only.
    cap_frame(1'b0, 24'h0, 32'h0000_0010);
    chk_frame("c3.key", 1'b0, 8, 136'h42, 32, KEY_OEL);
    ck("c3.keys", 136'(keys), 136'(6'b000010));

    // Cycle 4: control now 0x88|7; reset lands mid-byte of the data frame.
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c4.mode", 1'b1, 8, 136'h40, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c4.data", 1'b0, 136, DATA_NEW, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c4.ctrl", 1'b0, 8, 136'h8F, 0, 0);
    cap_frame(1'b0, 24'h0, 32'h0000_0010);
    chk_frame("c4.key", 1'b0, 8, 136'h42, 32, KEY_OEL);
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("c5.mode", 1'b1, 8, 136'h40, 0, 0);
    n = 0;
    while (strobe !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ck("c5.data_start", 136'(strobe), 136'(0));
    // 100 samples in: 4 setup + 12 bits, i.e. inside the second byte.
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    ck("mid.strobe", 136'(strobe), 136'(1));
    ck("mid.out_clk", 136'(out_clk_1), 136'(1));
    ck("mid.dio", 136'(dio), 136'(1));
    ck("mid.dio_oe", 136'(dio_oe), 136'(1));
    ck("mid.keys", 136'(keys), 136'(0));
    ck("mid.key_valid", 136'(key_valid), 136'(0));
    ck("mid.frame_done", 136'(frame_done), 136'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cap_frame(1'b0, 24'h0, 32'h0);
    chk_frame("post.mode", 1'b0, 8, 136'h40, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
